// File: rtl/fb_pkg.sv
// Frame buffer scheduler shared types and default geometry (800x600 screen, 4x downscale).
package fb_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR     = 2'd1,
    SWAP_WAIT = 2'd2
  } fb_state_t;

  localparam int H_VIS_DEF    = 800;
  localparam int V_VIS_DEF    = 600;
  localparam int PXL_SHIFT_DEF = 2;
  localparam int FB_W         = H_VIS_DEF >> PXL_SHIFT_DEF;
  localparam int FB_H         = V_VIS_DEF >> PXL_SHIFT_DEF;
  localparam int FB_ADDR_BITS = 1 + 8 + 8;
endpackage

// File: rtl/fb_sweep_counter.sv
// Raster x/y counter for the clear sweep: advances one pixel per enabled cycle, wraps x into y.
// last_o flags the final pixel combinationally; clr_i restarts at (0,0) on the next edge.
module fb_sweep_counter
  import fb_pkg::*;
#(
  parameter int X_BITS = 8,
  parameter int Y_BITS = 8,
  parameter int W      = FB_W,
  parameter int H      = FB_H
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [X_BITS-1:0] x_o,
  output logic [Y_BITS-1:0] y_o,
  output logic              last_o
);
  localparam logic [X_BITS-1:0] X_MAX = X_BITS'(W - 1);
  localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(H - 1);

  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic              x_last, y_last;

  assign x_last = (x_q == X_MAX);
  assign y_last = (y_q == Y_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_last && y_last;
endmodule

// File: rtl/fb_scheduler.sv
// Single-port frame buffer arbiter: display reads (same-cycle, never stalled) beat clear sweep beat drawer.
// Drawer is backpressured via wr_ready during visible pixels and while busy; bank swap waits for vblank start.
module fb_scheduler
  import fb_pkg::*;
#(
  parameter int H_VIS_AREA_PXL = H_VIS_DEF,
  parameter int V_VIS_AREA_PXL = V_VIS_DEF,
  parameter int H_NUM_BITS     = 11,
  parameter int V_NUM_BITS     = 10,
  parameter int PXL_SHIFT      = PXL_SHIFT_DEF,
  parameter int FB_X_BITS      = 8,
  parameter int FB_Y_BITS      = 8,
  parameter int COLOR_WIDTH    = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [H_NUM_BITS-1:0]             h_pxl_count,
  input  logic [V_NUM_BITS-1:0]             v_pxl_count,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [FB_X_BITS-1:0]              wr_x,
  input  logic [FB_Y_BITS-1:0]              wr_y,
  input  logic [COLOR_WIDTH-1:0]            wr_color,
  input  logic                              clear_req,
  input  logic [COLOR_WIDTH-1:0]            clear_color,
  input  logic                              swap_req,
  output logic                              busy,
  output logic                              swap_done,
  output logic                              front_bank,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [FB_Y_BITS+FB_X_BITS:0]      mem_addr,
  output logic [COLOR_WIDTH-1:0]            mem_wdata
);
  localparam int FBW = H_VIS_AREA_PXL >> PXL_SHIFT;
  localparam int FBH = V_VIS_AREA_PXL >> PXL_SHIFT;
  localparam logic [H_NUM_BITS-1:0] H_VIS = H_NUM_BITS'(H_VIS_AREA_PXL);
  localparam logic [V_NUM_BITS-1:0] V_VIS = V_NUM_BITS'(V_VIS_AREA_PXL);
  localparam logic [FB_X_BITS-1:0]  X_MAX = FB_X_BITS'(FBW - 1);
  localparam logic [FB_Y_BITS-1:0]  Y_MAX = FB_Y_BITS'(FBH - 1);

  fb_state_t               state_q, state_d;
  logic                    front_q, front_d;
  logic                    swap_done_q, swap_done_d;
  logic                    pend_q, pend_d;
  logic [COLOR_WIDTH-1:0]  clr_color_q, clr_color_d;

  logic                    sweep_clr, sweep_en, sweep_last;
  logic [FB_X_BITS-1:0]    sweep_x;
  logic [FB_Y_BITS-1:0]    sweep_y;
  logic [H_NUM_BITS-1:0]   h_fb;
  logic [V_NUM_BITS-1:0]   v_fb;
  logic                    disp_rd, vblank_start, wr_in_range;

  assign h_fb         = h_pxl_count >> PXL_SHIFT;
  assign v_fb         = v_pxl_count >> PXL_SHIFT;
  assign disp_rd      = (h_pxl_count < H_VIS) && (v_pxl_count < V_VIS);
  assign vblank_start = (h_pxl_count == '0) && (v_pxl_count == V_VIS);
  assign wr_in_range  = (wr_x <= X_MAX) && (wr_y <= Y_MAX);

  fb_sweep_counter #(
    .X_BITS (FB_X_BITS),
    .Y_BITS (FB_Y_BITS),
    .W      (FBW),
    .H      (FBH)
  ) u_sweep (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (sweep_clr),
    .en_i    (sweep_en),
    .x_o     (sweep_x),
    .y_o     (sweep_y),
    .last_o  (sweep_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      pend_q      <= 1'b0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      swap_done_q <= swap_done_d;
      pend_q      <= pend_d;
      clr_color_q <= clr_color_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_done_d = 1'b0;
    pend_d      = pend_q;
    clr_color_d = clr_color_q;
    sweep_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        // A simultaneous swap is remembered and honoured once the clear finishes.
        if (clear_req) begin
          state_d     = CLEAR;
          clr_color_d = clear_color;
          pend_d      = swap_req;
          sweep_clr   = 1'b1;
        end else if (swap_req) begin
          state_d = SWAP_WAIT;
        end
      end
      CLEAR: begin
        if (sweep_en && sweep_last) begin
          state_d = pend_q ? SWAP_WAIT : IDLE;
          pend_d  = 1'b0;
        end
      end
      SWAP_WAIT: begin
        if (vblank_start) begin
          front_d     = ~front_q;
          swap_done_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory port is combinational so a read lands the cycle after its counts, matching vga latency.
  always_comb begin
    wr_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    sweep_en  = 1'b0;
    if (reset_n) begin
      if (disp_rd) begin
        mem_en   = 1'b1;
        mem_addr = {front_q, v_fb[FB_Y_BITS-1:0], h_fb[FB_X_BITS-1:0]};
      end else begin
        case (state_q)
          IDLE: begin
            wr_ready = 1'b1;
            if (wr_valid && wr_in_range) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = {~front_q, wr_y, wr_x};
              mem_wdata = wr_color;
            end
          end
          CLEAR: begin
            sweep_en  = 1'b1;
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {~front_q, sweep_y, sweep_x};
            mem_wdata = clr_color_q;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy       = (state_q != IDLE);
  assign swap_done  = swap_done_q;
  assign front_bank = front_q;
endmodule

// File: tb/tb_fb_scheduler.sv
// Directed bench for fb_scheduler: scanout, drawer writes, clear sweep, bank swap and mid-clear reset.
module tb_fb_scheduler;
  import fb_pkg::*;

  logic        clk, reset_n;
  logic [10:0] h_pxl_count;
  logic [9:0]  v_pxl_count;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x, wr_y, wr_color;
  logic        clear_req, swap_req;
  logic [7:0]  clear_color;
  logic        busy, swap_done, front_bank, mem_en, mem_we;
  logic [FB_ADDR_BITS-1:0] mem_addr;
  logic [7:0]  mem_wdata;

  int n_vec = 0;
  int n_bad = 0;

  fb_scheduler dut (
    .clk(clk), .reset_n(reset_n), .h_pxl_count(h_pxl_count), .v_pxl_count(v_pxl_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color),
    .clear_req(clear_req), .clear_color(clear_color), .swap_req(swap_req),
    .busy(busy), .swap_done(swap_done), .front_bank(front_bank),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v);
    h_pxl_count = 11'(h);
    v_pxl_count = 10'(v);
    #1;
  endtask

  function automatic logic [31:0] pk(input int en, input int we, input int rdy,
                                     input int b, input int y, input int x);
    return 32'({en[0], we[0], rdy[0], b[0], y[7:0], x[7:0]});
  endfunction

  function automatic logic [31:0] obs();
    return 32'({mem_en, mem_we, wr_ready, mem_addr});
  endfunction

  initial begin
    int sx, sy, nw, nwe, c;
    reset_n = 1'b0; wr_valid = 1'b1; wr_x = 8'd5; wr_y = 8'd7; wr_color = 8'hE0;
    clear_req = 1'b0; swap_req = 1'b0; clear_color = 8'h00;
    drive(900, 10);
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_rdy", 32'(wr_ready), 0);
    chk("rst_flags", 32'({busy, swap_done, front_bank}), 0);
    tick(); tick();
    reset_n = 1'b1;

    for (int h = 0; h < 800; h++) begin
      drive(h, 0);
      chk("scan", obs(), pk(1, 0, 0, 0, 0, h >> 2));
      tick();
    end
    drive(850, 10);
    chk("wr_ok", obs(), pk(1, 1, 1, 1, 7, 5));
    chk("wr_dat", 32'(mem_wdata), 32'h0E0);
    tick();
    wr_x = 8'd200;
    drive(851, 10);
    chk("wr_xoob", 32'({mem_en, mem_we, wr_ready}), 1);
    tick();
    wr_x = 8'd5; wr_y = 8'd150;
    drive(852, 10);
    chk("wr_yoob", 32'({mem_en, mem_we, wr_ready}), 1);
    tick();
    wr_x = 8'd199; wr_y = 8'd149; wr_color = 8'h3C;
    drive(853, 10);
    chk("wr_edge", obs(), pk(1, 1, 1, 1, 149, 199));
    chk("wr_edge_dat", 32'(mem_wdata), 32'h03C);
    tick();
    wr_valid = 1'b0;
    drive(854, 10);
    chk("idle_free", 32'({mem_en, mem_we, wr_ready}), 1);
    tick();
    drive(4, 4);
    chk("disp_rd", obs(), pk(1, 0, 0, 0, 1, 1));
    tick();

    clear_color = 8'h1C; clear_req = 1'b1;
    drive(900, 10);
    chk("clr_busy0", 32'(busy), 0);
    tick();
    clear_req = 1'b0; clear_color = 8'hFF;
    sx = 0; sy = 0; nw = 0; nwe = 0; c = 0;
    while (nw < 30000) begin
      if (c % 16 == 0) begin
        drive(c % 800, 3);
        chk("clr_disp", obs(), pk(1, 0, 0, 0, 0, (c % 800) >> 2));
      end else begin
        drive(1000, 700);
        chk("clr_wr", obs(), pk(1, 1, 0, 1, sy, sx));
        chk("clr_dat", 32'(mem_wdata), 32'h01C);
        nw++;
        if (sx == 199) begin sx = 0; sy++; end else sx++;
      end
      chk("clr_busy", 32'(busy), 1);
      if (mem_we) nwe++;
      c++;
      tick();
    end
    drive(1000, 700);
    chk("clr_done_busy", 32'(busy), 0);
    chk("clr_done_en", 32'(mem_en), 0);
    chk("clr_we_cnt", nwe, 30000);
    tick();

    clear_color = 8'h55; clear_req = 1'b1; swap_req = 1'b1;
    drive(900, 10);
    tick();
    clear_req = 1'b0; swap_req = 1'b0;
    nwe = 0;
    for (int i = 0; i < 30000; i++) begin
      drive(1000, 700);
      if (mem_we && mem_addr[16]) nwe++;
      tick();
    end
    chk("cs_cnt", nwe, 30000);
    drive(1000, 700);
    chk("cs_wait_busy", 32'(busy), 1);
    chk("cs_wait_port", 32'({mem_en, wr_ready}), 0);
    tick();
    drive(5, 600);
    tick();
    drive(0, 600);
    chk("cs_pre", 32'({front_bank, swap_done}), 0);
    tick();
    drive(1, 600);
    chk("cs_front", 32'(front_bank), 1);
    chk("cs_done", 32'(swap_done), 1);
    chk("cs_idle", 32'(busy), 0);
    tick();
    drive(2, 600);
    chk("cs_pulse", 32'(swap_done), 0);
    tick();
    drive(8, 4);
    chk("cs_disp", obs(), pk(1, 0, 0, 1, 1, 2));
    tick();
    wr_valid = 1'b1; wr_x = 8'd3; wr_y = 8'd2; wr_color = 8'hAA;
    drive(850, 10);
    chk("cs_wr", obs(), pk(1, 1, 1, 0, 2, 3));
    tick();
    wr_valid = 1'b0;

    clear_color = 8'h77; clear_req = 1'b1; swap_req = 1'b1;
    drive(900, 10);
    tick();
    clear_req = 1'b0; swap_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(1000, 700);
      tick();
    end
    drive(1000, 700);
    chk("rm_wr100", obs(), pk(1, 1, 0, 0, 0, 100));
    reset_n = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 0);
    chk("rm_front", 32'(front_bank), 0);
    chk("rm_en", 32'(mem_en), 0);
    chk("rm_done", 32'(swap_done), 0);
    tick(); tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) drive(0, 600); else drive(1000, 700);
      chk("rm_after", 32'({busy, swap_done, front_bank, mem_en}), 0);
      tick();
    end

    swap_req = 1'b1;
    drive(0, 600);
    chk("vs_req_idle", 32'(busy), 0);
    tick();
    swap_req = 1'b0;
    drive(1, 600);
    chk("vs_front", 32'(front_bank), 0);
    chk("vs_done", 32'(swap_done), 0);
    chk("vs_busy", 32'(busy), 1);
    tick();
    clear_req = 1'b1;
    drive(900, 10);
    tick();
    clear_req = 1'b0;
    drive(0, 600);
    chk("vs_pre", 32'(front_bank), 0);
    tick();
    drive(1, 600);
    chk("vs_swap", 32'({front_bank, swap_done, busy}), 32'(3'b110));
    tick();
    drive(1000, 700);
    chk("vs_noclr", 32'({busy, mem_en}), 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
